// File: rtl/axi_dw_allocator_lc.sv
// Write-data allocator for one AXI master port. It steers W beats from the slave
// port named by the routing queue's head entry, counts beats, and checks each burst's length.
module axi_dw_allocator_lc #(
   parameter int AXI_DATA_W   = 64,
   parameter int AXI_NUMBYTES = AXI_DATA_W / 8,
   parameter int AXI_USER_W   = 6,
   parameter int N_TARG_PORT  = 7,
   parameter int LOG_N_TARG   = $clog2(N_TARG_PORT),
   parameter int FIFO_DEPTH   = 8,
   parameter int CNT_W        = $clog2(FIFO_DEPTH + 1),
   parameter int ENFORCE_LEN  = 1,
   parameter int REG_OUT      = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [N_TARG_PORT*AXI_DATA_W-1:0]    wdata_i,
   input  logic [N_TARG_PORT*AXI_NUMBYTES-1:0]  wstrb_i,
   input  logic [N_TARG_PORT-1:0]               wlast_i,
   input  logic [N_TARG_PORT*AXI_USER_W-1:0]    wuser_i,
   input  logic [N_TARG_PORT-1:0]               wvalid_i,
   output logic [N_TARG_PORT-1:0]               wready_o,
   output logic [AXI_DATA_W-1:0]                wdata_o,
   output logic [AXI_NUMBYTES-1:0]              wstrb_o,
   output logic                                 wlast_o,
   output logic [AXI_USER_W-1:0]                wuser_o,
   output logic                                 wvalid_o,
   input  logic                                 wready_i,
   input  logic                                 push_i,
   input  logic [LOG_N_TARG-1:0]                push_id_i,
   input  logic [7:0]                           push_len_i,
   output logic                                 push_gnt_o,
   output logic [CNT_W-1:0]                     fifo_cnt_o,
   output logic                                 len_err_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [LOG_N_TARG-1:0] id_mem_q  [FIFO_DEPTH];
   logic [7:0]            len_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7:0]            beat_q, beat_d;
   logic                  len_err_q, len_err_d;

   logic [LOG_N_TARG-1:0]   head_id;
   logic [7:0]              head_len;
   logic                    nonempty, acc, hs, lastgen, term, pop, push_acc;
   logic                    sel_valid, sel_last;
   logic [AXI_DATA_W-1:0]   sel_data;
   logic [AXI_NUMBYTES-1:0] sel_strb;
   logic [AXI_USER_W-1:0]   sel_user;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign nonempty   = (cnt_q != '0);
   assign head_id    = id_mem_q[rd_ptr_q];
   assign head_len   = len_mem_q[rd_ptr_q];
   assign push_gnt_o = (cnt_q < CNT_W'(FIFO_DEPTH));
   assign push_acc   = push_i & push_gnt_o;
   assign fifo_cnt_o = cnt_q;
   assign len_err_o  = len_err_q;

   // An id outside the port range matches no channel, so the queue simply stalls on it.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_strb  = '0;
      sel_user  = '0;
      wready_o  = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         if (nonempty && (head_id == LOG_N_TARG'(i))) begin
            sel_valid   = wvalid_i[i];
            sel_last    = wlast_i[i];
            sel_data    = wdata_i[i*AXI_DATA_W +: AXI_DATA_W];
            sel_strb    = wstrb_i[i*AXI_NUMBYTES +: AXI_NUMBYTES];
            sel_user    = wuser_i[i*AXI_USER_W +: AXI_USER_W];
            wready_o[i] = acc;
         end
      end
   end

   assign hs      = sel_valid & acc;
   assign lastgen = (beat_q == head_len);
   assign term    = (ENFORCE_LEN != 0) ? lastgen : sel_last;
   assign pop     = hs & term;

   always_comb begin
      cnt_d = cnt_q;
      if (push_acc && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!push_acc && pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      wr_ptr_d  = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      beat_d    = beat_q;
      if (hs) begin
         beat_d = pop ? 8'd0 : beat_q + 8'd1;
      end
      len_err_d = hs & (sel_last != lastgen);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         beat_q    <= '0;
         len_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         beat_q    <= beat_d;
         len_err_q <= len_err_d;
      end
   end

   // Entry storage needs no reset: it is only read while the occupancy says it is valid.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         id_mem_q[wr_ptr_q]  <= push_id_i;
         len_mem_q[wr_ptr_q] <= push_len_i;
      end
   end

   if (REG_OUT != 0) begin : g_reg_out
      logic                    vld_q, last_q;
      logic [AXI_DATA_W-1:0]   data_q;
      logic [AXI_NUMBYTES-1:0] strb_q;
      logic [AXI_USER_W-1:0]   user_q;

      assign acc = ~vld_q | wready_i;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
            user_q <= '0;
         end else if (hs) begin
            vld_q  <= 1'b1;
            last_q <= term;
            data_q <= sel_data;
            strb_q <= sel_strb;
            user_q <= sel_user;
         end else if (wready_i) begin
            vld_q  <= 1'b0;
         end
      end

      assign wvalid_o = vld_q;
      assign wlast_o  = last_q;
      assign wdata_o  = data_q;
      assign wstrb_o  = strb_q;
      assign wuser_o  = user_q;
   end else begin : g_comb_out
      assign acc      = wready_i;
      assign wvalid_o = sel_valid;
      assign wlast_o  = nonempty & term;
      assign wdata_o  = sel_data;
      assign wstrb_o  = sel_strb;
      assign wuser_o  = sel_user;
   end

endmodule

// File: doc/axi_dw_allocator_lc.md
Name: axi_dw_allocator_lc

Overview:
- Parametrised write-data allocator with length checking, one per AXI master port of the node.
- Selects one of N_TARG_PORT write-data channels using routing entries queued during the AW phase. Each entry holds the source port and the AWLEN.
- Tracks beats with a per-burst counter. Can generate WLAST from AWLEN instead of trusting the source.
- Flags WLAST/length mismatches. Has an optional output register slice for timing closure.

Parameters:
- AXI_DATA_W, 64, write data width
- AXI_NUMBYTES, AXI_DATA_W/8, strobe width
- AXI_USER_W, 6, W user sideband width
- N_TARG_PORT, 7, number of input (slave-port) channels, >=2
- LOG_N_TARG, $clog2(N_TARG_PORT), port index width
- FIFO_DEPTH, 8, routing entries outstanding, >=2
- CNT_W, $clog2(FIFO_DEPTH+1), occupancy width
- ENFORCE_LEN, 1, 1: WLAST derived from AWLEN; 0: WLAST passed from selected source
- REG_OUT, 1, 1: registered output slice; 0: combinational path

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wdata_i  in  N_TARG_PORT*AXI_DATA_W  per-port write data
- wstrb_i  in  N_TARG_PORT*AXI_NUMBYTES  per-port strobes
- wlast_i  in  N_TARG_PORT  per-port last flag
- wuser_i  in  N_TARG_PORT*AXI_USER_W  per-port user
- wvalid_i  in  N_TARG_PORT  per-port valid
- wready_o  out  N_TARG_PORT  per-port ready
- wdata_o  out  AXI_DATA_W  selected data
- wstrb_o  out  AXI_NUMBYTES  selected strobes
- wlast_o  out  1  last flag
- wuser_o  out  AXI_USER_W  selected user
- wvalid_o  out  1  output valid
- wready_i  in  1  downstream ready
- push_i  in  1  enqueue routing entry
- push_id_i  in  LOG_N_TARG  source port index, binary
- push_len_i  in  8  AWLEN (beats-1)
- push_gnt_o  out  1  queue can accept an entry
- fifo_cnt_o  out  CNT_W  queue occupancy
- len_err_o  out  1  one-cycle pulse on WLAST/length mismatch

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
  - Queue empties, beat counter clears to 0, output slice clears, len_err_o clears.
  - All outputs are 0 during reset and immediately after, except push_gnt_o, which is 1.
  - A reset mid-burst discards all queued entries and partial bursts. No state survives.
- Routing queue: FIFO_DEPTH entries of {id, len}, no fall-through.
  - push_gnt_o = (fifo_cnt_o < FIFO_DEPTH).
  - A push is accepted only when push_i & push_gnt_o. A push while full is dropped and the count is unchanged.
  - An entry pushed at cycle t is visible at the head at t+1.
  - Simultaneous push and pop: count is unchanged. When full, push_gnt_o=0 even if a pop occurs that cycle.
- Selection: s = head.id, valid only when the queue is non-empty.
  - If s >= N_TARG_PORT, no channel is selected and the queue stalls. Upstream never pushes such an id.
- Slice ready: acc = REG_OUT ? (~wvalid_o | wready_i) : wready_i.
- wready_o[i] = nonempty & (i==s) & acc. Every other bit is 0, and wready_o is all-zero when empty.
- Input handshake: hs = nonempty & wvalid_i[s] & acc.
- Beat counter beat_q (8 bit). Define lastgen = (beat_q == head.len).
  - ENFORCE_LEN=1: on hs, if lastgen then pop the head and set beat_q<=0; otherwise beat_q++. Output last = lastgen; wlast_i is ignored for termination.
  - ENFORCE_LEN=0: on hs, if wlast_i[s] then pop and set beat_q<=0; otherwise beat_q++, wrapping modulo 256. Output last = wlast_i[s].
- len_err_o is registered. It is 1 in the cycle after any hs where wlast_i[s] != lastgen, in both modes. It carries no other side effect.
- Datapath: {wdata, wstrb, last, wuser} is muxed from port s.
  - REG_OUT=0: outputs are combinational; wvalid_o = nonempty & wvalid_i[s]. Outputs are 0 when the queue is empty.
  - REG_OUT=1: single-entry slice. On hs, data loads and wvalid_o goes to 1. The slice clears on wready_i unless reloaded the same cycle. Latency is 1 cycle with full throughput. Data is held stable while wvalid_o & ~wready_i.
- Back-to-back bursts: a pop and the first beat of the next head occur in separate cycles.
  - The next head is used from the cycle after the pop.
  - Zero-bubble switching is not required. One dead cycle between bursts is acceptable.
- fifo_cnt_o is the registered occupancy.

Test Plan:
- Single beat: push id=2 len=0, then wvalid_i[2]=1 wlast_i[2]=1, REG_OUT=1, wready_i=1 -> wready_o=0b0000100, wvalid_o=1 one cycle later with wlast_o=1, fifo_cnt_o 1 then 0, len_err_o=0.
- Enforced length: ENFORCE_LEN=1, push id=0 len=3, port 0 sends 4 beats with wlast_i=0 on all -> wlast_o=1 on beat 4 only, entry popped, len_err_o pulses once after beat 4.
- Interleaved order: push id=1 len=1, then id=4 len=0, both ports valid -> port 1's two beats complete before wready_o[4] rises; port 4 never sees ready during port 1's burst.
- Full queue: push 8 entries with no W traffic -> fifo_cnt_o=8, push_gnt_o=0, 9th push dropped (count stays 8); after one burst completes, push_gnt_o returns to 1.
- Backpressure: REG_OUT=1, 3-beat burst, wready_i toggled 0/1 each cycle -> wdata_o stable while stalled, all 3 beats delivered in order, no duplicates or drops.
- Reset mid-burst: assert rst_n=0 after beat 2 of a 4-beat burst -> all outputs 0, fifo_cnt_o=0, push_gnt_o=1; a new id=3 len=0 burst completes normally after reset release.
